// File: rtl/uart_hex_tx_if.sv
// Request/response bundle between the line controller and the hex line transmitter.
interface uart_hex_tx_if;
    logic        start;
    logic [7:0]  tag;
    logic        tag_en;
    logic [15:0] data;
    logic        busy;
    logic        done;

    modport master (output start, tag, tag_en, data, input busy, done);
    modport slave  (input start, tag, tag_en, data, output busy, done);
endinterface

// File: rtl/uart_hex_tx.sv
// Sends "[tag]HHHH\r\n" for a captured 16-bit word as back-to-back 8N1 frames on uart_dout.
module uart_hex_tx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic          clk,
    input  logic          rst,
    uart_hex_tx_if.slave  bus,
    output logic          uart_dout
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0] IDX_FIRST_DIGIT = 3'd1;
    localparam logic [2:0] IDX_LF = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START_BIT,
        S_DATA,
        S_STOP,
        S_FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        tag_q, tag_d;
    logic [15:0]       data_q, data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              dout_q, dout_d;
    logic              baud_tick_c;
    logic [7:0]        cur_byte_c;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Character at a given position of the response line.
    function automatic logic [7:0] line_byte(input logic [2:0] idx, input logic [7:0] t,
                                             input logic [15:0] d);
        case (idx)
            3'd0:    return t;
            3'd1:    return hex_char(d[15:12]);
            3'd2:    return hex_char(d[11:8]);
            3'd3:    return hex_char(d[7:4]);
            3'd4:    return hex_char(d[3:0]);
            3'd5:    return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    assign baud_tick_c = (baud_q == BAUD_LAST);

    // State, counters, captured payload and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            tag_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
        end
    end

    // Next state and datapath.
    always_comb begin
        state_d = state_q;
        baud_d  = '0;
        bit_d   = bit_q;
        idx_d   = idx_q;
        tag_d   = tag_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    tag_d   = bus.tag;
                    data_d  = bus.data;
                    idx_d   = bus.tag_en ? 3'd0 : IDX_FIRST_DIGIT;
                    bit_d   = 3'd0;
                    state_d = S_START_BIT;
                end
            end
            S_START_BIT: begin
                baud_d = baud_tick_c ? '0 : baud_q + BAUD_W'(1);
                if (baud_tick_c) begin
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                baud_d = baud_tick_c ? '0 : baud_q + BAUD_W'(1);
                if (baud_tick_c) begin
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d = bit_q + 3'd1;
                end
            end
            S_STOP: begin
                baud_d = baud_tick_c ? '0 : baud_q + BAUD_W'(1);
                if (baud_tick_c) begin
                    if (idx_q == IDX_LF) begin
                        state_d = S_FINISH;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_START_BIT;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs follow the state being entered, so they register in step with it.
    always_comb begin
        busy_d     = 1'b0;
        done_d     = 1'b0;
        dout_d     = 1'b1;
        cur_byte_c = line_byte(idx_d, tag_d, data_d);
        case (state_d)
            S_START_BIT: begin busy_d = 1'b1; dout_d = 1'b0; end
            S_DATA:      begin busy_d = 1'b1; dout_d = cur_byte_c[bit_d]; end
            S_STOP:      busy_d = 1'b1;
            S_FINISH:    done_d = 1'b1;
            default:     ;
        endcase
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign uart_dout = dout_q;

endmodule

// File: tb/tb_uart_hex_tx.sv
// Randomized bench for uart_hex_tx: serial waveform and handshake checked against a line model.
module tb_uart_hex_tx;
    localparam int CPB = 4;

    logic clk;
    logic rst;
    logic uart_dout;
    uart_hex_tx_if bus();

    uart_hex_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .uart_dout (uart_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_bytes[$];
    logic       exp_bits[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference line: optional tag, four uppercase hex digits MSB first, CR, LF; 8N1 frames back to back.
    task automatic build_expected(input logic [7:0] t, input bit en, input logic [15:0] d);
        int nib;
        logic [7:0] b;
        exp_bytes.delete();
        exp_bits.delete();
        if (en) exp_bytes.push_back(t);
        for (int k = 0; k < 4; k++) begin
            nib = int'((d >> (12 - 4 * k)) & 16'hF);
            exp_bytes.push_back((nib < 10) ? 8'(48 + nib) : 8'(65 + nib - 10));
        end
        exp_bytes.push_back(8'h0D);
        exp_bytes.push_back(8'h0A);
        foreach (exp_bytes[i]) begin
            b = exp_bytes[i];
            exp_bits.push_back(1'b0);
            for (int j = 0; j < 8; j++) exp_bits.push_back(b[j]);
            exp_bits.push_back(1'b1);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the done cycle.
    task automatic run_line(input string name, input logic [7:0] t, input bit en,
                            input logic [15:0] d, input int poke);
        int n;
        int total;
        int wave_err;
        int busy_cnt;
        int done_cnt;
        logic samp[0:69];
        logic [7:0] got;
        build_expected(t, en, d);
        n = exp_bytes.size();
        total = n * 10 * CPB;
        bus.tag = t; bus.tag_en = en; bus.data = d; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.tag = ~t; bus.tag_en = ~en; bus.data = ~d;
        wave_err = 0; busy_cnt = 0; done_cnt = 0;
        for (int c = 0; c < total; c++) begin
            if (uart_dout !== exp_bits[c / CPB]) wave_err++;
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done !== 1'b0) done_cnt++;
            if (c % CPB == CPB / 2) samp[c / CPB] = uart_dout;
            if (poke >= 0 && c == poke) begin
                bus.start = 1'b1; bus.data = 16'h1234; bus.tag_en = 1'b1;
            end else if (poke >= 0 && c == poke + 1) begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) got[b] = samp[i * 10 + 1 + b];
            check($sformatf("%s_byte%0d", name, i), 32'(got), 32'(exp_bytes[i]));
        end
        check({name, "_wave_err"}, 32'(wave_err), 32'd0);
        check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(total));
        check({name, "_early_done"}, 32'(done_cnt), 32'd0);
        check({name, "_done"}, 32'(bus.done), 32'd1);
        check({name, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        check({name, "_dout_at_done"}, 32'(uart_dout), 32'd1);
    endtask

    task automatic after_done(input string name);
        @(negedge clk);
        check({name, "_done_pulse_end"}, 32'(bus.done), 32'd0);
        check({name, "_idle_dout"}, 32'(uart_dout), 32'd1);
    endtask

    initial begin
        int quiet_done;
        int quiet_busy;
        rst = 1'b1;
        bus.start = 1'b0; bus.tag = 8'h00; bus.tag_en = 1'b0; bus.data = 16'h0000;
        repeat (3) @(negedge clk);
        check("reset_dout", 32'(uart_dout), 32'd1);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_line("basic", 8'h72, 1'b1, 16'h3A0F, -1);
        after_done("basic");
        run_line("allf", 8'h72, 1'b0, 16'hFFFF, -1);
        after_done("allf");
        run_line("boundary", 8'h3F, 1'b0, 16'h09A0, -1);
        after_done("boundary");

        run_line("poke", 8'h41, 1'b1, 16'hBEEF, 100);
        quiet_done = 0; quiet_busy = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done !== 1'b0) quiet_done++;
            if (bus.busy !== 1'b0 || uart_dout !== 1'b1) quiet_busy++;
        end
        check("poke_extra_done", 32'(quiet_done), 32'd0);
        check("poke_no_second_line", 32'(quiet_busy), 32'd0);

        run_line("b2b_a", 8'h72, 1'b1, 16'h1357, -1);
        bus.start = 1'b1; bus.tag_en = 1'b0; bus.data = 16'h00FF;
        @(negedge clk);
        check("b2b_gap_busy", 32'(bus.busy), 32'd0);
        check("b2b_gap_dout", 32'(uart_dout), 32'd1);
        check("b2b_gap_done", 32'(bus.done), 32'd0);
        run_line("b2b_b", 8'h72, 1'b0, 16'h00FF, -1);
        after_done("b2b_b");

        bus.tag = 8'h52; bus.tag_en = 1'b1; bus.data = 16'(8'($urandom)); bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2 * 10 * CPB + CPB + 2) @(negedge clk);
        check("midframe_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_dout", 32'(uart_dout), 32'd1);
        check("rst_mid_busy", 32'(bus.busy), 32'd0);
        check("rst_mid_done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_dout", 32'(uart_dout), 32'd1);
        run_line("after_rst", 8'h72, 1'b1, 16'hC0DE, -1);
        after_done("after_rst");

        for (int r = 0; r < 6; r++) begin
            run_line($sformatf("rand%0d", r), 8'($urandom), 1'($urandom), 16'($urandom), -1);
            after_done($sformatf("rand%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
